div_unit: RTL and testbench

//  Multi-cycle RV64M divide/remainder responder for the execute stage. Execute drives en/newOp/operands.
//  div_unit raises busy while iterating and holds divOut stable once done.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit.sv | 107 ++++++++++
 tb/tb_div_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: opcode fields, FSM states and result helpers shared by div_unit.
package div_unit_pkg;
    typedef logic [2:0] div_op_t;
    localparam int DIVOP_WORD = 2;
    localparam int DIVOP_REM  = 1;
    localparam int DIVOP_UNS  = 0;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction
    // Word forms return bit 31 sign-extended, including the unsigned ones
    function automatic logic [63:0] pick_result(input div_op_t op, input logic [63:0] q, input logic [63:0] r);
        logic [63:0] v;
        v = op[DIVOP_REM] ? r : q;
        return op[DIVOP_WORD] ? {{32{v[31]}}, v[31:0]} : v;
    endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring RV64M divide/remainder unit.
// Build option DIV_EARLY_OUT_EN: special cases and |ia|<|ib| finish in the start cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_new_op,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_ia,
    input  logic [XLEN-1:0] i_ib,
    input  div_op_t         i_div_op,
    output logic            o_busy,
    output logic [XLEN-1:0] o_div_out
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN);
    div_state_t r_state, w_next;
    div_op_t r_op;
    logic [XLEN-1:0] r_dvd, r_dvs, r_rem, r_q, r_a_ext;
    logic [CW-1:0] r_cnt;
    logic r_neg_q, r_neg_r, r_div0, r_ovf;
    logic w_start, w_word, w_sgn, w_a_neg, w_b_neg, w_div0, w_ovf, w_early, w_last, w_ge;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_abs_a, w_abs_b, w_min, w_q, w_r;
    logic [XLEN:0] w_sh;
    assign w_word  = i_div_op[DIVOP_WORD];
    assign w_sgn   = ~i_div_op[DIVOP_UNS];
    assign w_a_ext = w_word ? {{HALF{w_sgn & i_ia[HALF-1]}}, i_ia[HALF-1:0]} : i_ia;
    assign w_b_ext = w_word ? {{HALF{w_sgn & i_ib[HALF-1]}}, i_ib[HALF-1:0]} : i_ib;
    assign w_a_neg = w_sgn & w_a_ext[XLEN-1];
    assign w_b_neg = w_sgn & w_b_ext[XLEN-1];
    assign w_abs_a = w_a_neg ? neg64(w_a_ext) : w_a_ext;
    assign w_abs_b = w_b_neg ? neg64(w_b_ext) : w_b_ext;
    assign w_min   = w_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0  = w_b_ext == '0;
    assign w_ovf   = w_sgn & (w_a_ext == w_min) & (&w_b_ext);
    assign w_start = i_en & i_new_op & (r_state == IDLE | r_state == DONE) & ~i_flush;
`ifdef DIV_EARLY_OUT_EN
    logic [XLEN-1:0] w_early_res;
    assign w_early = w_div0 | w_ovf | (w_abs_a < w_abs_b);
    assign w_early_res = pick_result(i_div_op, w_div0 ? {XLEN{1'b1}} : w_ovf ? w_a_ext : '0,
                                     w_ovf ? '0 : w_a_ext);
`else
    assign w_early = 1'b0;
`endif
    assign w_last = r_cnt == (r_op[DIVOP_WORD] ? CW'(HALF - 1) : CW'(XLEN - 1));
    // One extra bit: an unsigned remainder shifted left can exceed XLEN bits
    assign w_sh   = {r_rem, r_dvd[XLEN-1]};
    assign w_ge   = w_sh >= {1'b0, r_dvs};
    assign w_q    = r_div0 ? {XLEN{1'b1}} : r_ovf ? r_a_ext : r_neg_q ? neg64(r_q) : r_q;
    assign w_r    = r_div0 ? r_a_ext : r_ovf ? '0 : r_neg_r ? neg64(r_rem) : r_rem;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (i_flush) w_next = IDLE;
        else if (w_start) w_next = w_early ? DONE : CALC;
        else if (r_state == CALC) w_next = w_last ? FIX : CALC;
        else if (r_state == FIX) w_next = DONE;
        o_busy = ~rst & (w_start | r_state == CALC | r_state == FIX);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_a_ext   <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            o_div_out <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_op    <= i_div_op;
            r_dvd   <= w_word ? {w_abs_a[HALF-1:0], {HALF{1'b0}}} : w_abs_a;
            r_dvs   <= w_abs_b;
            r_rem   <= '0;
            r_q     <= '0;
            r_a_ext <= w_a_ext;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div0  <= w_div0;
            r_ovf   <= w_ovf;
`ifdef DIV_EARLY_OUT_EN
            if (w_early) o_div_out <= w_early_res;
`endif
        end else if (r_state == CALC) begin
            r_dvd <= r_dvd << 1;
            r_rem <= w_sh[XLEN-1:0] - (w_ge ? r_dvs : '0);
            r_q   <= {r_q[XLEN-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
        end else if (r_state == FIX) begin
            o_div_out <= pick_result(r_op, w_q, w_r);
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized self-checking bench for div_unit.
module tb_div_unit;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, new_op = 1'b0, flush = 1'b0;
    logic [63:0] ia = '0, ib = '0;
    logic [2:0]  div_op = '0;
    logic        busy;
    logic [63:0] div_out;
    int n_cmp = 0, n_err = 0;
    always #5 clk = ~clk;
    div_unit dut (
        .clk(clk), .rst(rst), .i_en(en), .i_new_op(new_op), .i_flush(flush),
        .i_ia(ia), .i_ib(ib), .i_div_op(div_op), .o_busy(busy), .o_div_out(div_out)
    );
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // RISC-V M-extension semantics from plain arithmetic; op = {word, rem, uns}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r;
        logic [31:0] a32, b32, q32, r32;
        if (op[2]) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
            else if (op[0]) begin q32 = a32 / b32; r32 = a32 % b32; end
            else begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 0) begin q = '1; r = a; end
            else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; end
            else if (op[0]) begin q = a / b; r = a % b; end
            else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        end
        return op[1] ? r : q;
    endfunction
    function automatic int exp_cycles(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic [63:0] xa, xb, ma, mb;
        xa = op[2] ? {{32{!op[0] & a[31]}}, a[31:0]} : a;
        xb = op[2] ? {{32{!op[0] & b[31]}}, b[31:0]} : b;
        ma = (!op[0] && xa[63]) ? -xa : xa;
        mb = (!op[0] && xb[63]) ? -xb : xb;
        if (xb == 0 || ma < mb) return 1;
        if (!op[0] && xb == '1 && xa == (op[2] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
`endif
        return op[2] ? 34 : 66;
    endfunction
    task automatic run(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] prev;
        int cyc;
        bit held;
        @(negedge clk);
        en = 1'b1; new_op = 1'b1; div_op = op; ia = a; ib = b;
        prev = div_out; held = 1'b1; cyc = 0;
        #1;
        while (busy === 1'b1 && cyc < 200) begin
            held &= (div_out === prev);
            @(posedge clk);
            #1 new_op = 1'b0;
            cyc++;
        end
        check({tag, " cycles"}, 64'(cyc), 64'(exp_cycles(op, a, b)));
        check({tag, " hold"}, 64'(held), 64'd1);
        check(tag, div_out, model(op, a, b));
    endtask
    initial begin
        logic [63:0] prev, ra, rb;
        logic [2:0]  rop;
        en = 1'b1; new_op = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset out", div_out, 64'd0);
        new_op = 1'b0; en = 1'b0;
        @(negedge clk) rst = 1'b0;
        #1 check("idle busy", 64'(busy), 64'd0);
        run("DIV -7/2", 3'b000, -64'sd7, 64'd2);
        run("REM -7/2", 3'b010, -64'sd7, 64'd2);
        run("DIVU max/16", 3'b001, '1, 64'h10);
        run("REMU max/16", 3'b011, '1, 64'h10);
        run("DIV 5/0", 3'b000, 64'd5, 64'd0);
        run("REM 5/0", 3'b010, 64'd5, 64'd0);
        run("DIV ovf", 3'b000, 64'h8000_0000_0000_0000, '1);
        run("REM ovf", 3'b010, 64'h8000_0000_0000_0000, '1);
        run("DIVW ovf", 3'b100, 64'h0000_0001_8000_0000, '1);
        run("DIVUW", 3'b101, 64'hFFFF_FFFE, 64'd1);
        // Flush ten cycles into CALC
        @(negedge clk);
        en = 1'b1; new_op = 1'b1; div_op = 3'b000; ia = 64'd1000; ib = 64'd3;
        prev = div_out;
        @(posedge clk);
        #1 new_op = 1'b0;
        repeat (9) @(posedge clk);
        #1 check("calc busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush out", div_out, prev);
        run("DIV 100/7", 3'b000, 64'd100, 64'd7);
        // Flush beats a start issued in DONE
        @(negedge clk);
        new_op = 1'b1; flush = 1'b1; div_op = 3'b010; ia = 64'd50; ib = 64'd9;
        #1 check("flush vs start busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0; new_op = 1'b0;
        check("flush vs start idle", 64'(busy), 64'd0);
        check("flush vs start out", div_out, 64'd14);
        // Reset mid-CALC
        @(negedge clk);
        new_op = 1'b1; div_op = 3'b000; ia = 64'd100; ib = 64'd7;
        @(posedge clk);
        #1 new_op = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check("rst busy", 64'(busy), 64'd0);
        check("rst out", div_out, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("post rst busy", 64'(busy), 64'd0);
        run("b2b DIV 100/7", 3'b000, 64'd100, 64'd7);
        run("b2b REM 100/7", 3'b010, 64'd100, 64'd7);
        run("DIVU 3/9", 3'b001, 64'd3, 64'd9);
        run("REMW -9/4", 3'b110, 64'h1234_5678_FFFF_FFF7, 64'd4);
        run("REMUW max/7", 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7);
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ;
                1: begin ra = 64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 40)); end
                2: begin rb = $urandom_range(0, 1) ? '0 : '1; ra = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000; end
                default: begin rb = 64'($signed($urandom_range(0, 255)) - 128); end
            endcase
            run($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
